// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_unit
// Brief    : Fetch-stage program counter with jump/branch/call/return and a
//            circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
  parameter int                 ADDR_W     = 8,
  parameter int                 OFF_W      = 8,
  parameter int                 RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         jump_en,
  input  logic [ADDR_W-1:0]            jump_target,
  input  logic                         branch_en,
  input  logic [OFF_W-1:0]             branch_off,
  input  logic                         call_en,
  input  logic                         ret_en,
  output logic [ADDR_W-1:0]            pc,
  output logic                         redirect,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] c_pc_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  c_ptr_one = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_depth   = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic              r_redirect;
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_red_nxt;
  logic [PTR_W-1:0]  w_top_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;
  logic              w_push;

  // Offset is sign-extended to the PC width before the modular add
  if (OFF_W < ADDR_W) begin : g_sext
    assign w_off_ext = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
  end else begin : g_nosext
    assign w_off_ext = branch_off[ADDR_W-1:0];
  end

  assign w_pc_inc = r_pc + c_pc_one;

  always_comb begin
    w_pc_nxt  = r_pc;
    w_red_nxt = 1'b0;
    w_top_nxt = r_top;
    w_cnt_nxt = r_count;
    w_ovf_nxt = r_ovf;
    w_unf_nxt = r_unf;
    w_push    = 1'b0;
    if (!stall) begin
      if (ret_en) begin
        if (r_count != '0) begin
          w_pc_nxt  = r_ras[r_top];
          w_top_nxt = r_top - c_ptr_one;
          w_cnt_nxt = r_count - c_cnt_one;
          w_red_nxt = 1'b1;
        end else begin
          w_pc_nxt  = w_pc_inc;
          w_unf_nxt = 1'b1;
        end
      end else if (call_en) begin
        // Full stack: the write pointer wraps onto the oldest entry
        w_push    = 1'b1;
        w_pc_nxt  = jump_target;
        w_top_nxt = r_top + c_ptr_one;
        w_red_nxt = 1'b1;
        if (r_count == c_depth) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_count + c_cnt_one;
        end
      end else if (jump_en) begin
        w_pc_nxt  = jump_target;
        w_red_nxt = 1'b1;
      end else if (branch_en) begin
        w_pc_nxt  = r_pc + w_off_ext;
        w_red_nxt = 1'b1;
      end else begin
        w_pc_nxt  = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_ADDR;
      r_redirect <= 1'b0;
      r_top      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_redirect <= w_red_nxt;
      r_top      <= w_top_nxt;
      r_count    <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_unf      <= w_unf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_ras[w_top_nxt] <= w_pc_inc;
    end
  end

  assign pc            = r_pc;
  assign redirect      = r_redirect;
  assign ras_count     = r_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_stack_unit
// Brief    : Directed plus randomized bench for pc_stack_unit against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst, stall, jump_en, branch_en, call_en, ret_en;
  logic [7:0] jump_target, branch_off;
  logic [7:0] pc;
  logic       redirect, ras_overflow, ras_underflow;
  logic [2:0] ras_count;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] m_pc;
  logic       m_red, m_ovf, m_unf;
  logic [7:0] m_q[$];

  pc_stack_unit #(.ADDR_W(8), .OFF_W(8), .RAS_DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_en(jump_en),
    .jump_target(jump_target), .branch_en(branch_en), .branch_off(branch_off),
    .call_en(call_en), .ret_en(ret_en), .pc(pc), .redirect(redirect),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic s, input logic rt, input logic cl,
                        input logic jp, input logic br, input logic [7:0] tgt,
                        input logic [7:0] off);
    rst = r; stall = s; ret_en = rt; call_en = cl; jump_en = jp; branch_en = br;
    jump_target = tgt; branch_off = off;
  endtask

  // Reference model: return stack kept as a bounded queue, newest at the back
  task automatic model_edge();
    if (rst) begin
      m_pc = 8'h00; m_red = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_q.delete();
    end else if (stall) begin
      m_red = 1'b0;
    end else if (ret_en) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_back(); m_red = 1'b1;
      end else begin
        m_pc = m_pc + 8'd1; m_unf = 1'b1; m_red = 1'b0;
      end
    end else if (call_en) begin
      m_q.push_back(m_pc + 8'd1);
      if (m_q.size() > 4) begin
        void'(m_q.pop_front()); m_ovf = 1'b1;
      end
      m_pc = jump_target; m_red = 1'b1;
    end else if (jump_en) begin
      m_pc = jump_target; m_red = 1'b1;
    end else if (branch_en) begin
      m_pc = m_pc + branch_off; m_red = 1'b1;
    end else begin
      m_pc = m_pc + 8'd1; m_red = 1'b0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("redirect", redirect, m_red);
    chk("ras_count", ras_count, m_q.size());
    chk("ras_overflow", ras_overflow, m_ovf);
    chk("ras_underflow", ras_underflow, m_unf);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    step();
  endtask

  initial begin
    m_pc = 8'h00; m_red = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    step(); step();
    chk("reset_pc", pc, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      idle();
      chk("incr_pc", pc, i);
    end

    // jump, branch and wrap-around
    set_in(0, 0, 0, 0, 1, 0, 8'hF0, 8'h00); step();
    chk("jump_pc", pc, 8'hF0); chk("jump_redirect", redirect, 1'b1);
    set_in(0, 0, 0, 0, 0, 1, 8'h00, 8'h10); step();
    chk("branch_wrap", pc, 8'h00);
    set_in(0, 0, 0, 0, 0, 1, 8'h00, 8'hFE); step();
    chk("branch_neg", pc, 8'hFE);
    idle(); chk("idle_ff", pc, 8'hFF);
    idle(); chk("idle_wrap", pc, 8'h00); chk("idle_redirect", redirect, 1'b0);
    set_in(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); step();
    chk("branch_zero_pc", pc, 8'h00); chk("branch_zero_red", redirect, 1'b1);

    // nested call/return
    set_in(0, 0, 0, 0, 1, 0, 8'h10, 8'h00); step();
    set_in(0, 0, 0, 1, 0, 0, 8'h40, 8'h00); step();
    chk("call1_pc", pc, 8'h40); chk("call1_cnt", ras_count, 3'd1);
    idle();
    set_in(0, 0, 0, 1, 0, 0, 8'h80, 8'h00); step();
    chk("call2_cnt", ras_count, 3'd2);
    set_in(0, 0, 1, 0, 0, 0, 8'h00, 8'h00); step();
    chk("ret1_pc", pc, 8'h42);
    step();
    chk("ret2_pc", pc, 8'h11); chk("ret2_cnt", ras_count, 3'd0);

    // overflow then underflow: return addresses 12,21,31,41,51
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 1, 0, 0, 8'h20 + 8'(i * 16), 8'h00); step();
    end
    chk("ovf_flag", ras_overflow, 1'b1); chk("ovf_cnt", ras_count, 3'd4);
    set_in(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    step(); chk("pop_a5", pc, 8'h51);
    step(); chk("pop_a4", pc, 8'h41);
    step(); chk("pop_a3", pc, 8'h31);
    step(); chk("pop_a2", pc, 8'h21);
    step(); chk("unf_pc", pc, 8'h22); chk("unf_flag", ras_underflow, 1'b1);

    // stall and priority
    set_in(0, 0, 0, 1, 0, 0, 8'h70, 8'h00); step();
    set_in(0, 1, 0, 0, 1, 0, 8'hAA, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 8'h70); chk("stall_red", redirect, 1'b0);
    end
    set_in(0, 0, 1, 1, 1, 0, 8'hAA, 8'h00); step();
    chk("prio_pc", pc, 8'h23); chk("prio_cnt", ras_count, 3'd0);

    // reset during stall mid-operation
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 1, 0, 0, 8'h90 + 8'(i), 8'h00); step();
    end
    chk("pre_rst_cnt", ras_count, 3'd3);
    set_in(1, 1, 0, 0, 0, 0, 8'h00, 8'h00); step();
    chk("rst_pc", pc, 8'h00); chk("rst_cnt", ras_count, 3'd0);
    chk("rst_ovf", ras_overflow, 1'b0); chk("rst_unf", ras_underflow, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
             8'($urandom), 8'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the CPU fetch stage. It holds the instruction address and selects the next address each cycle: sequential increment, absolute jump, PC-relative branch, subroutine call, or return. It adds a circular return-address stack (RAS) for call/return. All state changes happen on a single clock edge, and a stall input freezes the whole unit.

## Interface
Parameters:
- ADDR_W, 8, width of the PC, jump target and return addresses
- OFF_W, 8, width of the signed branch offset (OFF_W <= ADDR_W)
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)
- RESET_ADDR, 0, PC value loaded by reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold all state (PC, RAS, flags) this cycle
- jump_en  in  1  absolute jump to jump_target
- jump_target  in  ADDR_W  target for jump and call
- branch_en  in  1  PC-relative branch
- branch_off  in  OFF_W  signed two's-complement offset, relative to the current PC
- call_en  in  1  push return address, go to jump_target
- ret_en  in  1  pop return address into PC
- pc  out  ADDR_W  current fetch address (registered)
- redirect  out  1  one-cycle pulse: the last update was non-sequential
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries
- ras_overflow  out  1  sticky: a call was made with the RAS full
- ras_underflow  out  1  sticky: a return was made with the RAS empty

## Operation
- Reset (rst=1, overrides stall):
  - pc=RESET_ADDR
  - RAS pointer and count=0
  - redirect=0, ras_overflow=0, ras_underflow=0
  - RAS storage contents are don't-care.
- stall=1, rst=0: every register holds; redirect goes to 0.
- Otherwise exactly one action is taken per cycle. Priority is ret_en > call_en > jump_en > branch_en > increment.
  - Return, count>0: pc<=top entry; count-=1; redirect=1.
  - Return, count=0: pc<=pc+1; ras_underflow<=1; redirect=0.
  - Call:
    - push pc+1 (mod 2^ADDR_W); pc<=jump_target; redirect=1.
    - If count=RAS_DEPTH, the oldest entry is overwritten (circular write pointer), count stays RAS_DEPTH, and ras_overflow<=1.
  - Jump: pc<=jump_target; redirect=1.
  - Branch: pc<=pc + sign_extend(branch_off), truncated to ADDR_W; redirect=1.
  - Increment: pc<=pc+1; redirect=0.
- All PC arithmetic is modulo 2^ADDR_W. Wrap-around is silent (0xFF+1=0x00 for ADDR_W=8).
- Branch with offset 0 targets the current PC. It still asserts redirect.
- The RAS is a circular buffer with a top pointer.
  - Push writes at top+1.
  - Pop reads at top, then decrements top.
  - After an overflow, the deepest RAS_DEPTH returns are still correct.
- Sticky flags clear only on rst.

## Timing
- Single clock domain. No negedge or combinational state updates.
- Latency of one cycle: the control inputs sampled at edge N determine pc after edge N.
- redirect is registered and is valid in the same cycle as the new pc.
- Call and return in the same cycle: the return wins, no push occurs, and ras_count decreases by 1 (or underflow is flagged).
- rst asserted during a stall or mid call/return sequence: the reset state takes effect at that edge and the RAS is emptied.
- Inputs must be stable around the rising edge. There are no handshakes; control inputs are level-sampled each non-stalled cycle.

## Test plan
- Reset and increment: rst for 2 cycles, then 5 idle cycles -> pc=0,1,2,3,4,5; redirect=0; ras_count=0.
- Jump, branch, wrap (ADDR_W=8):
  - jump_target=0xF0 with jump_en -> pc=0xF0, redirect=1.
  - Then branch_off=0x10 -> pc=0x00.
  - Then branch_off=0xFE (-2) -> pc=0xFE.
  - Then idle -> pc=0xFF, then 0x00.
- Nested call/return:
  - At pc=0x10, call 0x40 -> pc=0x40, ras_count=1.
  - At pc=0x41, call 0x80 -> ras_count=2.
  - ret -> pc=0x42.
  - ret -> pc=0x11, ras_count=0.
- Overflow and underflow (RAS_DEPTH=4):
  - 5 calls from return addresses A1..A5 -> ras_overflow=1, ras_count=4.
  - 4 rets -> A5, A4, A3, A2.
  - 5th ret -> pc increments, ras_underflow=1.
- Stall and priority:
  - stall with jump_en=1 for 3 cycles -> pc and ras_count unchanged, redirect=0.
  - Release with ret_en, call_en, jump_en all 1 and count=1 -> pc=popped address, ras_count=0.
- Reset mid-operation: with ras_count=3 and overflow set, assert rst while stall=1 -> next cycle pc=RESET_ADDR, ras_count=0, both flags 0.
